// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline register with flush, freeze and an optional stall counter.
// Define PIPE_STAGE_PERF_CNT_EN to add the stall_cycles port and its saturating counter.
`timescale 1ns/1ps

module pipe_stage_reg #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 flush,
    input  logic                 freeze,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    output logic [1:0]           occupancy
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cycles
`endif
);

    if (WIDTH < 1 || WIDTH > 1024 || CNT_WIDTH < 1) begin : g_param_check
        $error("pipe_stage_reg: illegal WIDTH or CNT_WIDTH");
    end

    // State encoding equals the number of held entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             accept;
    logic             send;

    // NOTE: sequential blocks use non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) state_nxt = ONE;
                ONE: begin
                    if (accept && !send)      state_nxt = FULL;
                    else if (!accept && send) state_nxt = EMPTY;
                end
                FULL:  if (send) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // in_ready depends only on registered state and freeze, never on out_ready.
    always_comb begin
        in_ready  = rst_b & ~freeze & (state != FULL);
        out_valid = ~freeze & (state != EMPTY);
        out_data  = main_q;
        occupancy = state;
    end

    assign accept = in_valid & in_ready;
    assign send   = out_valid & out_ready;

    // NOTE: the payload registers are reset because out_data must read 0
    // during reset; a plain datapath register would normally skip reset.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (!flush) begin
            case (state)
                EMPTY: if (accept) main_q <= in_data;
                ONE: begin
                    if (accept && send) main_q <= in_data;
                    else if (accept)    skid_q <= in_data;
                end
                FULL:  if (send) main_q <= skid_q;
                default: ;
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic stall_event;

    // Counts cycles where a held beat cannot leave; flush neither counts nor clears.
    assign stall_event = (state != EMPTY) & (freeze | ~out_ready) & ~flush;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            stall_cycles <= '0;
        end else if (stall_event && (stall_cycles != {CNT_WIDTH{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table plus reset and counter sequences,
// scored against a queue model of the held beats.
`timescale 1ns/1ps

module tb_pipe_stage_reg;
    localparam int WIDTH     = 8;
    localparam int CNT_WIDTH = 4;
    localparam int NVEC      = 29;

    logic             clk;
    logic             rst_b;
    logic             flush;
    logic             freeze;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       occupancy;
`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cycles;
`endif

    pipe_stage_reg #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .flush     (flush),
        .freeze    (freeze),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             vld;
        logic [WIDTH-1:0] data;
        logic             rdy;
        logic             frz;
        logic             fl;
        int               exp_occ;
    } vec_t;

    vec_t             vecs[NVEC];
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] emitted[$];
    int               model_cnt;
    int               checks;
    int               errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int i, input logic v, input logic [WIDTH-1:0] d,
                           input logic r, input logic f, input logic fl, input int occ);
        vecs[i].vld = v; vecs[i].data = d; vecs[i].rdy = r;
        vecs[i].frz = f; vecs[i].fl = fl;  vecs[i].exp_occ = occ;
    endtask

    // One clock: drive at negedge, check against the model, update the model, wait for posedge.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r,
                         input logic f, input logic fl, input int exp_occ);
        logic             exp_in_ready;
        logic             exp_out_valid;
        int               held;
        logic [WIDTH-1:0] popped;
        @(negedge clk);
        in_valid = v; in_data = d; out_ready = r; freeze = f; flush = fl;
        #1;
        held          = model_q.size();
        exp_in_ready  = !f && (held < 2);
        exp_out_valid = !f && (held > 0);
        check("in_ready", in_ready, exp_in_ready);
        check("out_valid", out_valid, exp_out_valid);
        check("occupancy", occupancy, held);
        if (exp_occ >= 0) check("vec_occupancy", occupancy, exp_occ);
        if (held > 0) check("out_data", out_data, model_q[0]);
`ifdef PIPE_STAGE_PERF_CNT_EN
        check("stall_cycles", stall_cycles, model_cnt);
`endif
        if (out_valid && out_ready && !flush) emitted.push_back(out_data);
        if (held != 0 && (f || !r) && !fl && model_cnt < (2**CNT_WIDTH - 1)) model_cnt++;
        if (fl) begin
            model_q.delete();
        end else begin
            if (exp_out_valid && r) popped = model_q.pop_front();
            if (v && exp_in_ready) model_q.push_back(d);
        end
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] exp_emit [7];
        int               c3_seen;
        int               n;
        exp_emit = '{8'h11, 8'h22, 8'h33, 8'hA1, 8'hA2, 8'hB1, 8'hB2};
        checks = 0; errors = 0; model_cnt = 0;

        // streaming
        set_vec(0,  1, 8'h11, 1, 0, 0, 0);
        set_vec(1,  1, 8'h22, 1, 0, 0, 1);
        set_vec(2,  1, 8'h33, 1, 0, 0, 1);
        set_vec(3,  0, 8'h00, 1, 0, 0, 1);
        set_vec(4,  0, 8'h00, 1, 0, 0, 0);
        // skid
        set_vec(5,  1, 8'hA1, 0, 0, 0, 0);
        set_vec(6,  1, 8'hA2, 0, 0, 0, 1);
        set_vec(7,  1, 8'hA9, 0, 0, 0, 2);
        set_vec(8,  0, 8'h00, 1, 0, 0, 2);
        set_vec(9,  0, 8'h00, 1, 0, 0, 1);
        set_vec(10, 0, 8'h00, 1, 0, 0, 0);
        // freeze while full
        set_vec(11, 1, 8'hB1, 0, 0, 0, 0);
        set_vec(12, 1, 8'hB2, 0, 0, 0, 1);
        set_vec(13, 1, 8'hEE, 1, 1, 0, 2);
        set_vec(14, 1, 8'hEE, 1, 1, 0, 2);
        set_vec(15, 1, 8'hEE, 1, 1, 0, 2);
        set_vec(16, 0, 8'h00, 1, 0, 0, 2);
        set_vec(17, 0, 8'h00, 1, 0, 0, 1);
        set_vec(18, 0, 8'h00, 1, 0, 0, 0);
        // flush when full, then flush with an accept in ONE
        set_vec(19, 1, 8'hC1, 0, 0, 0, 0);
        set_vec(20, 1, 8'hC2, 0, 0, 0, 1);
        set_vec(21, 1, 8'hC3, 0, 0, 1, 2);
        set_vec(22, 0, 8'h00, 1, 0, 0, 0);
        set_vec(23, 1, 8'hD1, 1, 0, 0, 0);
        set_vec(24, 1, 8'hD2, 0, 0, 1, 1);
        set_vec(25, 0, 8'h00, 1, 0, 0, 0);
        // flush wins over freeze
        set_vec(26, 1, 8'hE1, 0, 0, 0, 0);
        set_vec(27, 0, 8'h00, 1, 1, 1, 1);
        set_vec(28, 0, 8'h00, 1, 0, 0, 0);

        rst_b = 1'b0; flush = 0; freeze = 0; in_valid = 0; in_data = '0; out_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_out_data", out_data, 0);
        @(posedge clk);
        #2 rst_b = 1'b1;

        for (int i = 0; i < NVEC; i++)
            cycle(vecs[i].vld, vecs[i].data, vecs[i].rdy, vecs[i].frz, vecs[i].fl, vecs[i].exp_occ);

        check("emit_count", emitted.size(), 7);
        n = (emitted.size() < 7) ? emitted.size() : 7;
        for (int i = 0; i < n; i++) check("emit_order", emitted[i], exp_emit[i]);
        c3_seen = 0;
        foreach (emitted[i]) if (emitted[i] == 8'hC3 || emitted[i] == 8'hD2 || emitted[i] == 8'hEE) c3_seen++;
        check("flushed_never_emitted", c3_seen, 0);

        // asynchronous reset mid-cycle while holding one beat
        cycle(1, 8'h5A, 0, 0, 0, 0);
        #2 rst_b = 1'b0;
        in_valid = 0; out_ready = 1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_occupancy", occupancy, 0);
        check("async_rst_in_ready", in_ready, 0);
        check("async_rst_out_data", out_data, 0);
`ifdef PIPE_STAGE_PERF_CNT_EN
        check("async_rst_stall", stall_cycles, 0);
`endif
        model_q.delete();
        model_cnt = 0;
        @(posedge clk);
        #2 rst_b = 1'b1;
        cycle(1, 8'h66, 1, 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0, 1);
        cycle(0, 8'h00, 1, 0, 0, 0);
        check("post_rst_emit_count", emitted.size(), 8);
        if (emitted.size() > 0) check("post_rst_emit", emitted[emitted.size()-1], 8'h66);

`ifdef PIPE_STAGE_PERF_CNT_EN
        cycle(1, 8'h77, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 8'h00, 0, 0, 0, 1);
        @(negedge clk); #1;
        check("stall_saturated", stall_cycles, 15);
        cycle(0, 8'h00, 0, 0, 1, 1);
        @(negedge clk); #1;
        check("stall_kept_on_flush", stall_cycles, 15);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload width in bits, legal range 1..1024.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the stall counter.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_b  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous kill of all held entries.
REQ-006 SHALL have port freeze  input  1  global stall; holds all state.
REQ-007 SHALL have port in_valid  input  1  producer offers in_data.
REQ-008 SHALL have port in_data  input  WIDTH  producer payload.
REQ-009 SHALL have port in_ready  output  1  stage accepts in_data this cycle.
REQ-010 SHALL have port out_valid  output  1  out_data is valid for the consumer.
REQ-011 SHALL have port out_data  output  WIDTH  payload toward the consumer.
REQ-012 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-013 SHALL have port occupancy  output  2  number of held entries, 0..2.
REQ-014 SHALL have port stall_cycles  output  CNT_WIDTH  stall counter; present only with PIPE_STAGE_PERF_CNT_EN.

Function
REQ-015 SHALL implement a two-entry skid register: main entry drives out_data; skid entry catches one beat after a back-pressure event.
REQ-016 SHALL use states EMPTY (occupancy 0), ONE (1), FULL (2), encoded as occupancy.
REQ-017 SHALL define accept = in_valid & in_ready, and send = out_valid & out_ready.
REQ-018 SHALL drive in_ready = ~freeze & (state != FULL), with no combinational path from out_ready.
REQ-019 SHALL drive out_valid = ~freeze & (state != EMPTY); out_data = main entry, also held during freeze.
REQ-020 SHALL apply these transitions: EMPTY+accept -> ONE, with main loaded; ONE+accept+send -> ONE, with main reloaded; ONE+accept only -> FULL, with the skid loaded; ONE+send only -> EMPTY; FULL+send -> ONE, with skid moved to main; in all other cases the state is held.
REQ-021 SHALL have a latency of 1 cycle, from accept to out_valid, and a sustained throughput of 1 beat per cycle with out_ready held high.
REQ-022 SHALL preserve strict FIFO order, with no beat dropped or duplicated.
REQ-023 SHALL, with freeze=1, perform no accept or send and change neither state nor payload registers.
REQ-024 SHALL, with flush=1 at an edge, set state to EMPTY and discard any simultaneous accept and send; payload registers keep their values.
REQ-025 SHALL give flush priority over freeze.
REQ-026 SHALL make a beat presented with flush=1 invisible downstream.

Reset
REQ-027 SHALL, on rst_b low, immediately set state to EMPTY, both payload registers to 0, and stall_cycles to 0, independent of clk.
REQ-028 SHALL hold out_valid=0, in_ready=0, out_data=0 and occupancy=0 while rst_b is low.
REQ-029 SHALL accept its first beat on the first rising edge after rst_b deasserts.
REQ-030 SHALL, on reset mid-operation, lose all held beats, with none emitted afterwards.

Configuration
REQ-031 SHALL, with macro PIPE_STAGE_PERF_CNT_EN defined, increment stall_cycles each cycle where (state != EMPTY) & (freeze | ~out_ready) and flush=0, saturating at all-ones.
REQ-032 SHALL not clear stall_cycles on flush.
REQ-033 SHALL, without PIPE_STAGE_PERF_CNT_EN, omit the stall_cycles port and counter logic; all other behaviour is identical.

Verification
REQ-034 SHALL cover streaming: out_ready=1, beats 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later each, with occupancy never above 1.
REQ-035 SHALL cover skid: out_ready=0, send 0xA1 then 0xA2 -> occupancy 2 and in_ready=0; then out_ready=1 -> 0xA1 then 0xA2, with occupancy back to 0.
REQ-036 SHALL cover freeze: FULL with 0xB1,0xB2, freeze=1 for 3 cycles with out_ready=1 -> out_valid=0, in_ready=0, occupancy 2; after release -> 0xB1, 0xB2 in order.
REQ-037 SHALL cover flush: FULL, then flush=1 with in_valid=1 and data 0xC3 -> next cycle occupancy 0 and out_valid=0; 0xC3 is never emitted.
REQ-038 SHALL cover async reset: rst_b low mid-clock in state ONE -> out_valid=0 and occupancy=0 before the next edge; stall_cycles=0.
REQ-039 SHALL cover the counter (macro on, CNT_WIDTH=4): 20 cycles of out_ready=0 with one beat held -> stall_cycles saturates at 15.
